// File: rtl/sme_pkg.sv
// sme_pkg: character constants, FSM state encoding and case folding
// shared by the string-matching engine.
package sme_pkg;
   localparam logic [7:0] NUL    = 8'h00;
   localparam logic [7:0] LF     = 8'h0A;
   localparam logic [7:0] DOT    = 8'h2E;
   localparam logic [7:0] HAT    = 8'h5E;
   localparam logic [7:0] DOLLAR = 8'h24;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_EMIT, S_NEXT, S_DONE} state_e;

   function automatic logic [7:0] fold_case(input logic [7:0] c, input logic ci);
      return (ci && c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
   endfunction
endpackage

// File: rtl/sme_pat_buf.sv
// sme_pat_buf: local copy of the current pattern plus its length and
// anchor flags; length saturates at MAX_PAT_LEN+1 to flag overlong patterns.
module sme_pat_buf
   import sme_pkg::*;
#(
   parameter int MAX_PAT_LEN = 16,
   localparam int LW = $clog2(MAX_PAT_LEN + 2),
   localparam int IW = (MAX_PAT_LEN > 1) ? $clog2(MAX_PAT_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          we_i,
   input  logic [7:0]    wdata_i,
   input  logic [IW-1:0] raddr_i,
   output logic [7:0]    rdata_o,
   output logic [LW-1:0] len_o,
   output logic          hat_o,
   output logic          dol_o
);
   logic [7:0]    mem_q [MAX_PAT_LEN];
   logic [LW-1:0] len_q;

   always_ff @(posedge clk)
      if (we_i && len_q < LW'(MAX_PAT_LEN)) mem_q[IW'(len_q)] <= wdata_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) len_q <= '0;
      else if (clr_i) len_q <= '0;
      else if (we_i && len_q <= LW'(MAX_PAT_LEN)) len_q <= len_q + 1'b1;

   assign rdata_o = mem_q[raddr_i];
   assign len_o   = len_q;
   assign hat_o   = (len_q != '0) && mem_q[0] == HAT;
   // a lone '^' is an anchor, not the trailing '$' of an empty body
   assign dol_o   = (len_q > LW'(hat_o)) && mem_q[IW'(len_q - 1'b1)] == DOLLAR;
endmodule

// File: rtl/sme_multi_stream.sv
// sme_multi_stream: scans a NUL-terminated text against a list of patterns
// ('.', leading '^', trailing '$') and streams every (pattern, address) hit.
module sme_multi_stream
   import sme_pkg::*;
#(
   parameter int TEXT_AW     = 12,
   parameter int PAT_AW      = 7,
   parameter int MAX_PAT_LEN = 16,
   parameter int NUM_PAT     = 16,
   localparam int PNW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   localparam int LW  = $clog2(MAX_PAT_LEN + 2),
   localparam int IW  = (MAX_PAT_LEN > 1) ? $clog2(MAX_PAT_LEN) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               case_insensitive_i,
   output logic [TEXT_AW-1:0] t_addr_o,
   input  logic [7:0]         t_data_i,
   output logic [PAT_AW-1:0]  p_addr_o,
   input  logic [7:0]         p_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [PNW-1:0]     pattern_no_o,
   output logic [TEXT_AW-1:0] match_addr_o,
   output logic               pat_err_o,
   output logic               busy_o,
   output logic               finish_o
);
   state_e             state_q;
   logic [TEXT_AW-1:0] s_q, t_addr_q, match_addr_q;
   logic [PAT_AW-1:0]  p_addr_q;
   logic [PNW-1:0]     pattern_no_q;
   logic [LW-1:0]      i_q, len, hat_w, body_end;
   logic               look_q, ci_q, out_valid_q, busy_q, finish_q, pat_err_q;
   logic [7:0]         rdata;
   logic               hat, dol, clr, we, off0, t_nul, t_lf, chr_ok, tail_ok, need_look;

   sme_pat_buf #(.MAX_PAT_LEN(MAX_PAT_LEN)) u_buf (
      .clk(clk), .rst_n(rst_n), .clr_i(clr), .we_i(we), .wdata_i(p_data_i),
      .raddr_i(i_q[IW-1:0]), .rdata_o(rdata), .len_o(len), .hat_o(hat), .dol_o(dol)
   );

   always_comb begin
      clr       = state_q == S_NEXT || ((state_q == S_IDLE || state_q == S_DONE) && start_i);
      we        = state_q == S_LOAD && p_data_i != NUL;
      hat_w     = LW'(hat);
      body_end  = len - LW'(dol);
      off0      = i_q == hat_w;
      t_nul     = t_data_i == NUL;
      t_lf      = t_data_i == LF;
      chr_ok    = (rdata == DOT) ? !(t_nul || t_lf) : fold_case(rdata, ci_q) == fold_case(t_data_i, ci_q);
      tail_ok   = !dol || t_nul || t_lf;
      need_look = hat && s_q != '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= S_IDLE;
         s_q          <= '0;
         t_addr_q     <= '0;
         match_addr_q <= '0;
         p_addr_q     <= '0;
         pattern_no_q <= '0;
         i_q          <= '0;
         look_q       <= 1'b0;
         ci_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         finish_q     <= 1'b0;
         pat_err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE:
               if (start_i) begin
                  state_q      <= S_LOAD;
                  p_addr_q     <= '0;
                  pattern_no_q <= '0;
                  pat_err_q    <= 1'b0;
                  ci_q         <= case_insensitive_i;
                  busy_q       <= 1'b1;
                  finish_q     <= 1'b0;
               end
            S_LOAD: begin
               p_addr_q <= p_addr_q + 1'b1;
               if (p_data_i == NUL) begin
                  if (len == '0) begin
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     finish_q <= 1'b1;
                  end else if (len > LW'(MAX_PAT_LEN)) begin
                     pat_err_q <= 1'b1;
                     state_q   <= S_NEXT;
                  end else begin
                     state_q  <= S_SCAN;
                     s_q      <= '0;
                     t_addr_q <= '0;
                     i_q      <= hat_w;
                     look_q   <= 1'b0;
                  end
               end
            end
            S_SCAN: begin
               // default is a move to the next window; paths that stay override it
               s_q      <= s_q + 1'b1;
               t_addr_q <= s_q + 1'b1;
               i_q      <= hat_w;
               look_q   <= 1'b0;
               if (look_q) begin
                  if (t_lf) begin
                     state_q      <= S_EMIT;
                     out_valid_q  <= 1'b1;
                     match_addr_q <= s_q;
                  end
               end else if (off0 && t_nul) begin
                  state_q <= S_NEXT;
               end else if (i_q == body_end) begin
                  if (tail_ok && need_look) begin
                     s_q      <= s_q;
                     look_q   <= 1'b1;
                     t_addr_q <= s_q - 1'b1;
                  end else if (tail_ok) begin
                     state_q      <= S_EMIT;
                     out_valid_q  <= 1'b1;
                     match_addr_q <= s_q;
                  end
               end else if (chr_ok) begin
                  s_q      <= s_q;
                  i_q      <= i_q + 1'b1;
                  t_addr_q <= t_addr_q + 1'b1;
               end
            end
            S_EMIT:
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_SCAN;
               end
            S_NEXT:
               if (pattern_no_q == PNW'(NUM_PAT - 1)) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  finish_q <= 1'b1;
               end else begin
                  pattern_no_q <= pattern_no_q + 1'b1;
                  state_q      <= S_LOAD;
               end
            default: state_q <= S_IDLE;
         endcase
      end

   assign t_addr_o     = t_addr_q;
   assign p_addr_o     = p_addr_q;
   assign out_valid_o  = out_valid_q;
   assign pattern_no_o = pattern_no_q;
   assign match_addr_o = match_addr_q;
   assign pat_err_o    = pat_err_q;
   assign busy_o       = busy_q;
   assign finish_o     = finish_q;
endmodule

// File: tb/tb_sme_multi_stream.sv
// tb_sme_multi_stream: directed runs of the matcher against small text and
// pattern ROMs, checking the ordered hit list, stalls, pat_err and reset.
module tb_sme_multi_stream;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci = 1'b0, ready = 1'b0;
   logic [11:0] t_addr, match_addr;
   logic [6:0]  p_addr;
   logic [7:0]  t_data, p_data;
   logic [3:0]  pattern_no;
   logic        out_valid, pat_err, busy, finish;
   logic [7:0]  tmem [4096];
   logic [7:0]  pmem [128];
   int          checks = 0, errors = 0;
   int          got[$], exp_q[$];

   sme_multi_stream dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .case_insensitive_i(ci),
      .t_addr_o(t_addr), .t_data_i(t_data), .p_addr_o(p_addr), .p_data_i(p_data),
      .out_valid_o(out_valid), .out_ready_i(ready), .pattern_no_o(pattern_no),
      .match_addr_o(match_addr), .pat_err_o(pat_err), .busy_o(busy), .finish_o(finish)
   );

   always #5 clk = ~clk;
   assign t_data = tmem[t_addr];
   assign p_data = pmem[p_addr];

   function automatic int r(input int pn, input int a);
      return pn * 65536 + a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic load_t(input string s);
      foreach (tmem[k]) tmem[k] = 8'h00;
      for (int k = 0; k < s.len(); k++) tmem[k] = s[k];
   endtask

   // '|' stands for a pattern terminator; the list terminator is appended
   task automatic load_p(input string s);
      foreach (pmem[k]) pmem[k] = 8'h00;
      for (int k = 0; k < s.len(); k++) pmem[k] = (s[k] == 8'h7C) ? 8'h00 : s[k];
   endtask

   task automatic run(input string tag, input bit c, input int stall);
      int cyc = 0, wc = 0;
      bit held = 1'b0;
      int hv = 0;
      got.delete();
      ready = (stall == 0);
      ci = c;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk($sformatf("%s busy_after_start", tag), busy, 1);
      chk($sformatf("%s finish_after_start", tag), finish, 0);
      while (finish !== 1'b1 && cyc < 3000) begin
         if (out_valid === 1'b1) begin
            if (!held) begin
               held = 1'b1;
               hv = r(int'(pattern_no), int'(match_addr));
               wc = 0;
            end else chk($sformatf("%s stable", tag), r(int'(pattern_no), int'(match_addr)), hv);
            if (wc < stall) begin
               ready = 1'b0;
               wc++;
            end else begin
               ready = 1'b1;
               got.push_back(hv);
               held = 1'b0;
            end
         end else ready = (stall == 0);
         @(negedge clk);
         cyc++;
      end
      chk($sformatf("%s finished", tag), finish, 1);
      chk($sformatf("%s busy_done", tag), busy, 0);
      chk($sformatf("%s count", tag), got.size(), exp_q.size());
      foreach (exp_q[k]) chk($sformatf("%s hit%0d", tag, k), (k < got.size()) ? got[k] : -1, exp_q[k]);
   endtask

   initial begin
      int cyc;
      load_t("");
      load_p("");
      repeat (3) @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst finish", finish, 0);
      chk("rst pat_err", pat_err, 0);
      chk("rst t_addr", t_addr, 0);
      chk("rst p_addr", p_addr, 0);
      chk("rst pattern_no", pattern_no, 0);
      chk("rst match_addr", match_addr, 0);
      rst_n = 1'b1;

      load_t("abcabc");
      load_p("abc|");
      exp_q = '{r(0, 0), r(0, 3)};
      run("basic", 1'b0, 0);
      chk("basic pat_err", pat_err, 0);

      load_t("aXa\nab");
      load_p("^a.|b$|");
      exp_q = '{r(0, 0), r(0, 4), r(1, 5)};
      run("anchors", 1'b0, 0);

      load_t("xaya");
      load_p("aaaaaaaaaaaaaaaaaaaa|a|");
      exp_q = '{r(1, 1), r(1, 3)};
      run("longpat", 1'b0, 0);
      chk("longpat pat_err", pat_err, 1);

      load_t("ABab");
      load_p("ab|");
      exp_q = '{r(0, 2)};
      run("case_sens", 1'b0, 0);
      chk("case_sens pat_err_cleared", pat_err, 0);
      exp_q = '{r(0, 0), r(0, 2)};
      run("case_insens", 1'b1, 0);

      load_t("aaaa");
      load_p("aa|");
      exp_q = '{r(0, 0), r(0, 1), r(0, 2)};
      run("stall", 1'b0, 5);

      ready = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      chk("mid valid", out_valid, 1);
      chk("mid match_addr", match_addr, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst busy", busy, 0);
      chk("midrst match_addr", match_addr, 0);
      chk("midrst t_addr", t_addr, 0);
      chk("midrst p_addr", p_addr, 0);
      @(negedge clk) rst_n = 1'b1;
      run("rerun", 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
